// File: rtl/alu_psr_writeback_if.sv
// alu_psr_writeback_if: bundles the ALU-result handshake, the PSR restore
// port, the register-file write port and the status outputs of the
// execute-to-writeback stage.
// "slave" is the stage's own view. "master" is the view of the surrounding
// ALU/register-file environment.
interface alu_psr_writeback_if #(
  parameter int AW = 4,
  parameter int DW = 16
);
  // ALU result handshake
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_opcode;
  logic [DW-1:0] in_result;
  logic [4:0]    in_flags;
  logic [AW-1:0] in_rdest;
  // software PSR restore
  logic          psr_load;
  logic [4:0]    psr_wdata;
  // register-file write port
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          rf_ready;
  // status back to the ALU / software
  logic [4:0]    psr;
  logic          carry_out;
  logic          illegal_op;

  modport slave (
    input  in_valid, in_opcode, in_result, in_flags, in_rdest,
    input  psr_load, psr_wdata, rf_ready,
    output in_ready, wb_valid, wb_addr, wb_data, psr, carry_out, illegal_op
  );

  modport master (
    output in_valid, in_opcode, in_result, in_flags, in_rdest,
    output psr_load, psr_wdata, rf_ready,
    input  in_ready, wb_valid, wb_addr, wb_data, psr, carry_out, illegal_op
  );
endinterface

// File: rtl/alu_psr_writeback.sv
// alu_psr_writeback: execute-to-writeback stage behind the 16-bit ALU.
// Updates the 5-bit PSR ([0]N [1]L [2]F [3]C [4]Z) through a per-opcode
// flag mask and queues register-file writes in a DEPTH-entry circular
// buffer that drains through a ready-gated write port.
// Optional macro ALU_PSR_CARRY_BYPASS_EN: when defined, carry_out forwards
// the accepted op's raw carry in the same cycle, so carry chains can run
// back to back. When it is undefined, carry_out is always psr[3].
module alu_psr_writeback #(
  parameter int DEPTH = 2,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input logic               clk,
  input logic               reset,
  alu_psr_writeback_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // decoded opcode class
  typedef struct packed {
    logic       wb;       // result goes to the register file
    logic       illegal;  // undefined opcode
    logic [4:0] mask;     // PSR bits that take the raw flags
  } op_info_t;

  // Maps an ALU opcode to its writeback/mask class. 1010 is not a defined
  // ALU operation, so it is treated like 0000.
  function automatic op_info_t decode_op(input logic [3:0] op);
    op_info_t info;
    case (op)
      4'b0110, 4'b0100:          info = '{wb: 1'b1, illegal: 1'b0, mask: 5'b11000};
      4'b0101, 4'b0111, 4'b1001: info = '{wb: 1'b1, illegal: 1'b0, mask: 5'b10100};
      4'b1011, 4'b1000:          info = '{wb: 1'b0, illegal: 1'b0, mask: 5'b00011};
      4'b0001, 4'b0010, 4'b0011: info = '{wb: 1'b1, illegal: 1'b0, mask: 5'b10000};
      4'b1100, 4'b1101,
      4'b1110, 4'b1111:          info = '{wb: 1'b1, illegal: 1'b0, mask: 5'b00000};
      default:                   info = '{wb: 1'b0, illegal: 1'b1, mask: 5'b00000};
    endcase
    return info;
  endfunction

  // state
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic          in_ready_q, in_ready_d;
  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic [4:0]    psr_q, psr_d;
  logic          illegal_q, illegal_d;

  // handshake / decode
  op_info_t info_s;
  logic     accept_s;
  logic     push_s;
  logic     pop_s;
  logic     carry_s;

  // Decode the incoming opcode and derive accept/push/pop strobes.
  always_comb begin
    info_s   = decode_op(bus.in_opcode);
    accept_s = bus.in_valid & in_ready_q;
    push_s   = accept_s & info_s.wb;
    pop_s    = wb_valid_q & bus.rf_ready;
  end

  // Next pointers and occupancy. A push and a pop together leave count unchanged.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // in_ready depends only on the next occupancy, never on rf_ready directly.
  always_comb begin
    in_ready_d = (count_d < DEPTH_C);
    wb_valid_d = (count_d != '0);
  end

  // Next head entry. The entry being pushed becomes the head when it lands in
  // the slot the read pointer points at next (empty buffer, or a single
  // entry popped in the same cycle). Otherwise the head comes from storage.
  always_comb begin
    wb_addr_d = addr_mem_q[rd_ptr_d];
    wb_data_d = data_mem_q[rd_ptr_d];
    if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      wb_addr_d = bus.in_rdest;
      wb_data_d = bus.in_result;
    end else begin
      wb_addr_d = addr_mem_q[rd_ptr_d];
      wb_data_d = data_mem_q[rd_ptr_d];
    end
  end

  // PSR next state: a restore wins over the accepted op's flag update.
  always_comb begin
    psr_d = psr_q;
    if (bus.psr_load) begin
      psr_d = bus.psr_wdata;
    end else if (accept_s) begin
      psr_d = (psr_q & ~info_s.mask) | (bus.in_flags & info_s.mask);
    end else begin
      psr_d = psr_q;
    end
  end

  // Sticky flag for undefined opcodes.
  always_comb begin
    illegal_d = illegal_q;
    if (accept_s && info_s.illegal) begin
      illegal_d = 1'b1;
    end else begin
      illegal_d = illegal_q;
    end
  end

`ifdef ALU_PSR_CARRY_BYPASS_EN
  // Forward the raw carry of an accepted carry-writing op in the same cycle.
  always_comb begin
    carry_s = psr_q[3];
    if (accept_s && info_s.mask[3] && !bus.psr_load) begin
      carry_s = bus.in_flags[3];
    end else begin
      carry_s = psr_q[3];
    end
  end
`else
  // Carry to the ALU comes straight from the registered PSR.
  always_comb begin
    carry_s = psr_q[3];
  end
`endif

  // Buffer storage write on push. Reset also clears the queued data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
    end else if (push_s) begin
      addr_mem_q[wr_ptr_q] <= bus.in_rdest;
      data_mem_q[wr_ptr_q] <= bus.in_result;
    end
  end

  // Pointer, occupancy and handshake registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Registered write-port outputs, holding the head entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // PSR and sticky illegal-opcode registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psr_q     <= 5'b00000;
      illegal_q <= 1'b0;
    end else begin
      psr_q     <= psr_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_addr    = wb_addr_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.psr        = psr_q;
  assign bus.carry_out  = carry_s;
  assign bus.illegal_op = illegal_q;

endmodule
